array_tile_scheduler: RTL and testbench
=======================================

ARRAY_TILE_SCHEDULER -- requirements
Module: array_tile_scheduler

Interface
REQ-001 Parameter TILE_W, 8, width of tile-count fields and tile indices.
REQ-002 Parameter ARG_W, 16, width of the command argument field.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 job_valid  input  1  job descriptor offered.
REQ-006 job_ready  output  1  scheduler accepts a job (high only in IDLE).
REQ-007 job_k_tiles  input  TILE_W  number of reduction tiles; 0 is treated as 1.
REQ-008 job_n_tiles  input  TILE_W  number of output-column tiles; 0 is treated as 1.
REQ-009 abort  input  1  synchronous abort request.
REQ-010 cb_cmd_valid / cb_cmd_ready  output / input  1 / 1  column-buffer command handshake.
REQ-011 rb_cmd_valid / rb_cmd_ready  output / input  1 / 1  row-buffer command handshake.
REQ-012 rq_cmd_valid / rq_cmd_ready  output / input  1 / 1  requant command handshake.
REQ-013 cmd_op  output  3  opcode, shared by all three ports: OP_LOAD_W, OP_FEED_ACC, OP_FEED_CLR, OP_REQUANT.
REQ-014 cmd_arg  output  ARG_W  {n_idx, k_idx}, zero-extended.
REQ-015 cb_done / rb_done / rq_done  input  1 each  single-cycle completion pulses from each chain.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 job_done  output  1  single-cycle pulse when a job completes or is aborted.
REQ-018 err  output  1  sticky protocol-error flag; cleared on job acceptance.

Function
REQ-019 The scheduler SHALL implement the states IDLE, ISSUE_W, WAIT_W, ISSUE_F, WAIT_F, ISSUE_Q, WAIT_Q and FINISH.
REQ-020 In IDLE, a job_valid&&job_ready handshake SHALL latch both tile counts, set k_idx=0 and n_idx=0, clear err, and move to ISSUE_W.
REQ-021 ISSUE_W SHALL hold cb_cmd_valid=1 with cmd_op=OP_LOAD_W until cb_cmd_ready, then move to WAIT_W; WAIT_W SHALL move to ISSUE_F on cb_done.
REQ-022 ISSUE_F SHALL hold rb_cmd_valid with OP_FEED_CLR when k_idx==0 and OP_FEED_ACC otherwise, and move to WAIT_F on rb_cmd_ready.
REQ-023 On rb_done in WAIT_F: if k_idx<k_tiles-1, the scheduler SHALL increment k_idx and return to ISSUE_W; otherwise it SHALL move to ISSUE_Q.
REQ-024 ISSUE_Q SHALL issue OP_REQUANT on the rq port; on rq_done in WAIT_Q: if n_idx<n_tiles-1, the scheduler SHALL set k_idx=0, increment n_idx and go to ISSUE_W; otherwise it SHALL go to FINISH.
REQ-025 FINISH SHALL last exactly one cycle, assert job_done, and return to IDLE.
REQ-026 At most one *_cmd_valid SHALL be high in any cycle; cmd_op and cmd_arg SHALL remain stable while a valid is high and not yet accepted.
REQ-027 A cmd_valid is a 1-cycle minimum pulse: if ready is already high on entry to an ISSUE state, the handshake SHALL complete in that same cycle.
REQ-028 A done pulse arriving in any state other than its own WAIT state SHALL set err and SHALL otherwise be ignored.
REQ-029 A done pulse arriving in the same cycle as the matching cmd handshake SHALL be treated as early, set err, and not advance the state.
REQ-030 When abort=1 in any non-IDLE state, the scheduler SHALL drop all valids and go to FINISH the next cycle, regardless of an outstanding handshake; abort in IDLE SHALL be ignored.
REQ-031 Indices SHALL never wrap: k_idx<k_tiles and n_idx<n_tiles at all times.
REQ-032 A single-tile job (1,1) SHALL complete in 7 cycles after acceptance when every ready and done responds in zero or one cycle.

Reset
REQ-033 While rstn=0, the scheduler SHALL be in IDLE with all *_cmd_valid, busy, job_done and err at 0, job_ready at 1, indices and counts at 0, and cmd_op/cmd_arg at 0.
REQ-034 Reset asserted mid-job SHALL abandon the job without a job_done pulse.

Structure
REQ-035 The opcode enum (3-bit), the state enum and the argument packing SHALL be placed in RISA_PKG.
REQ-036 The design SHALL be a single FSM module with the index counters; the three command ports SHALL share one registered cmd_op/cmd_arg with per-port valid decode, and no sub-module is required.

Verification
REQ-037 Job (k=2,n=2) with all readies tied to 1 and dones 1 cycle after issue -> op sequence W,FCLR,W,FACC,Q,W,FCLR,W,FACC,Q with args 0x0000,0x0000,0x0001,0x0001,0x0001,0x0100,0x0100,0x0101,0x0101,0x0101, then one job_done pulse.
REQ-038 cb_cmd_ready held low for 5 cycles -> cb_cmd_valid, cmd_op and cmd_arg stable for all 6 cycles, and no other valid asserted.
REQ-039 rq_done pulsed while in WAIT_W -> err=1, state unchanged; err clears on the next job acceptance.
REQ-040 abort asserted in WAIT_F of (k=3,n=1) -> valids low, job_done the cycle after, then IDLE with job_ready=1.
REQ-041 Job (k=0,n=0) -> behaves as (1,1), and job_done arrives 7 cycles after acceptance.
REQ-042 rstn dropped during ISSUE_Q -> rq_cmd_valid=0 asynchronously, no job_done pulse, and a following job runs normally.

Source files
------------

// File: rtl/risa_pkg.sv
// risa_pkg: opcodes, scheduler states and command-argument packing for array_tile_scheduler.
package risa_pkg;
  typedef enum logic [2:0] {
    OP_NONE     = 3'd0,
    OP_LOAD_W   = 3'd1,
    OP_FEED_ACC = 3'd2,
    OP_FEED_CLR = 3'd3,
    OP_REQUANT  = 3'd4
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_W, S_WAIT_W, S_ISSUE_F, S_WAIT_F, S_ISSUE_Q, S_WAIT_Q, S_FINISH
  } state_e;
  // Argument is {n_idx, k_idx}; callers truncate to their ARG_W.
  function automatic logic [63:0] pack_arg(input logic [31:0] n_idx, input logic [31:0] k_idx,
                                           input int tile_w);
    return (64'(n_idx) << tile_w) | 64'(k_idx);
  endfunction
endpackage

// File: rtl/array_tile_scheduler.sv
// array_tile_scheduler: sequences weight-load, feed and requant commands over a k x n tile job.
module array_tile_scheduler
  import risa_pkg::*;
#(
  parameter int TILE_W = 8,
  parameter int ARG_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [TILE_W-1:0] job_k_tiles,
  input  logic [TILE_W-1:0] job_n_tiles,
  input  logic              abort,
  output logic              cb_cmd_valid,
  input  logic              cb_cmd_ready,
  output logic              rb_cmd_valid,
  input  logic              rb_cmd_ready,
  output logic              rq_cmd_valid,
  input  logic              rq_cmd_ready,
  output logic [2:0]        cmd_op,
  output logic [ARG_W-1:0]  cmd_arg,
  input  logic              cb_done,
  input  logic              rb_done,
  input  logic              rq_done,
  output logic              busy,
  output logic              job_done,
  output logic              err
);
  state_e            r_state, w_state_nxt;
  logic [TILE_W-1:0] r_k_tiles, r_n_tiles, r_k_idx, r_n_idx, w_k_nxt, w_n_nxt;
  logic [2:0]        r_cmd_op, w_op_nxt;
  logic [ARG_W-1:0]  r_cmd_arg, w_arg_nxt;
  logic              r_err, w_accept, w_k_last, w_n_last, w_stray, w_abort, w_issue_nxt;
  assign w_accept = job_valid && job_ready;
  assign w_abort  = abort && r_state != S_IDLE;
  assign w_k_last = r_k_idx == r_k_tiles - TILE_W'(1);
  assign w_n_last = r_n_idx == r_n_tiles - TILE_W'(1);
  // A done outside its own WAIT state (including one coincident with its handshake) is a protocol error.
  assign w_stray  = (cb_done && r_state != S_WAIT_W) || (rb_done && r_state != S_WAIT_F) ||
                    (rq_done && r_state != S_WAIT_Q);
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k_idx;
    w_n_nxt     = r_n_idx;
    if (w_abort) w_state_nxt = (r_state == S_FINISH) ? S_IDLE : S_FINISH;
    else
      case (r_state)
        S_IDLE: if (w_accept) begin
          w_state_nxt = S_ISSUE_W;
          w_k_nxt     = '0;
          w_n_nxt     = '0;
        end
        S_ISSUE_W: if (cb_cmd_ready) w_state_nxt = S_WAIT_W;
        S_WAIT_W:  if (cb_done) w_state_nxt = S_ISSUE_F;
        S_ISSUE_F: if (rb_cmd_ready) w_state_nxt = S_WAIT_F;
        S_WAIT_F:  if (rb_done) begin
          w_state_nxt = w_k_last ? S_ISSUE_Q : S_ISSUE_W;
          w_k_nxt     = w_k_last ? r_k_idx : r_k_idx + TILE_W'(1);
        end
        S_ISSUE_Q: if (rq_cmd_ready) w_state_nxt = S_WAIT_Q;
        S_WAIT_Q:  if (rq_done) begin
          w_state_nxt = w_n_last ? S_FINISH : S_ISSUE_W;
          w_k_nxt     = w_n_last ? r_k_idx : '0;
          w_n_nxt     = w_n_last ? r_n_idx : r_n_idx + TILE_W'(1);
        end
        default: w_state_nxt = S_IDLE;
      endcase
  end
  // Command fields are loaded on entry to an issue state so they are stable while valid waits.
  assign w_issue_nxt = w_state_nxt == S_ISSUE_W || w_state_nxt == S_ISSUE_F || w_state_nxt == S_ISSUE_Q;
  assign w_op_nxt    = (w_state_nxt == S_ISSUE_W) ? OP_LOAD_W :
                       (w_state_nxt == S_ISSUE_F) ? ((w_k_nxt == '0) ? OP_FEED_CLR : OP_FEED_ACC) :
                       (w_state_nxt == S_ISSUE_Q) ? OP_REQUANT : r_cmd_op;
  assign w_arg_nxt   = w_issue_nxt ? ARG_W'(pack_arg(32'(w_n_nxt), 32'(w_k_nxt), TILE_W)) : r_cmd_arg;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_k_tiles <= '0;
      r_n_tiles <= '0;
      r_k_idx   <= '0;
      r_n_idx   <= '0;
      r_cmd_op  <= '0;
      r_cmd_arg <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_k_idx   <= w_k_nxt;
      r_n_idx   <= w_n_nxt;
      r_cmd_op  <= w_op_nxt;
      r_cmd_arg <= w_arg_nxt;
      r_err     <= w_accept ? 1'b0 : (r_err || w_stray);
      if (w_accept) begin
        r_k_tiles <= (job_k_tiles == '0) ? TILE_W'(1) : job_k_tiles;
        r_n_tiles <= (job_n_tiles == '0) ? TILE_W'(1) : job_n_tiles;
      end
    end
  end
  assign job_ready    = r_state == S_IDLE;
  assign busy         = r_state != S_IDLE;
  assign job_done     = r_state == S_FINISH;
  assign err          = r_err;
  assign cb_cmd_valid = r_state == S_ISSUE_W && !abort;
  assign rb_cmd_valid = r_state == S_ISSUE_F && !abort;
  assign rq_cmd_valid = r_state == S_ISSUE_Q && !abort;
  assign cmd_op       = r_cmd_op;
  assign cmd_arg      = r_cmd_arg;
endmodule

// File: tb/tb_array_tile_scheduler.sv
// tb_array_tile_scheduler: directed self-checking bench for array_tile_scheduler.
module tb_array_tile_scheduler;
  import risa_pkg::*;
  logic clk = 0, rstn = 0, job_valid = 0, abort = 0;
  logic [7:0] job_k_tiles = 0, job_n_tiles = 0;
  logic cb_cmd_ready = 1, rb_cmd_ready = 1, rq_cmd_ready = 1;
  logic cb_done = 0, rb_done = 0, rq_done = 0;
  logic job_ready, cb_cmd_valid, rb_cmd_valid, rq_cmd_valid, busy, job_done, err;
  logic [2:0] cmd_op;
  logic [15:0] cmd_arg;
  int n_vec = 0, n_bad = 0, jd_cnt = 0, multi_cnt = 0, jd_snap, lat, c;
  bit auto_done = 0;
  logic [2:0] op_q[$];
  logic [15:0] arg_q[$];
  logic [2:0] exp_op[10] = '{OP_LOAD_W, OP_FEED_CLR, OP_LOAD_W, OP_FEED_ACC, OP_REQUANT,
                             OP_LOAD_W, OP_FEED_CLR, OP_LOAD_W, OP_FEED_ACC, OP_REQUANT};
  logic [15:0] exp_arg[10] = '{16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0001,
                               16'h0100, 16'h0100, 16'h0101, 16'h0101, 16'h0101};

  array_tile_scheduler #(.TILE_W(8), .ARG_W(16)) dut (
    .clk(clk), .rstn(rstn), .job_valid(job_valid), .job_ready(job_ready),
    .job_k_tiles(job_k_tiles), .job_n_tiles(job_n_tiles), .abort(abort),
    .cb_cmd_valid(cb_cmd_valid), .cb_cmd_ready(cb_cmd_ready),
    .rb_cmd_valid(rb_cmd_valid), .rb_cmd_ready(rb_cmd_ready),
    .rq_cmd_valid(rq_cmd_valid), .rq_cmd_ready(rq_cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cb_done(cb_done), .rb_done(rb_done), .rq_done(rq_done),
    .busy(busy), .job_done(job_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic submit(input logic [7:0] k, input logic [7:0] n);
    job_k_tiles = k;
    job_n_tiles = n;
    job_valid = 1;
    @(posedge clk); #1;
    job_valid = 0;
  endtask

  task automatic wait_done(input string tag);
    int cnt;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!job_done && cnt < 300);
    chk(tag, 32'(job_done), 1);
  endtask

  // Chain model: records accepted commands and returns each done one cycle after its handshake.
  initial begin : chain_model
    logic hc, hr, hq;
    forever begin
      @(negedge clk);
      hc = cb_cmd_valid && cb_cmd_ready;
      hr = rb_cmd_valid && rb_cmd_ready;
      hq = rq_cmd_valid && rq_cmd_ready;
      if (hc || hr || hq) begin op_q.push_back(cmd_op); arg_q.push_back(cmd_arg); end
      if (job_done) jd_cnt++;
      if (int'(cb_cmd_valid) + int'(rb_cmd_valid) + int'(rq_cmd_valid) > 1) multi_cnt++;
      @(posedge clk); #1;
      if (auto_done) begin cb_done = hc; rb_done = hr; rq_done = hq; end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    chk("rst_ready", 32'(job_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valids", 32'({cb_cmd_valid, rb_cmd_valid, rq_cmd_valid}), 0);
    chk("rst_done_err", 32'({job_done, err}), 0);
    chk("rst_op", 32'(cmd_op), 0);
    chk("rst_arg", 32'(cmd_arg), 0);
    @(posedge clk); #1 rstn = 1;
    @(posedge clk); #1;
    // k=2,n=2 full sequence
    auto_done = 1;
    op_q.delete(); arg_q.delete();
    submit(2, 2);
    wait_done("k2n2_done");
    chk("k2n2_len", 32'(op_q.size()), 10);
    for (int i = 0; i < 10 && i < op_q.size(); i++) begin
      chk($sformatf("k2n2_op%0d", i), 32'(op_q[i]), 32'(exp_op[i]));
      chk($sformatf("k2n2_arg%0d", i), 32'(arg_q[i]), 32'(exp_arg[i]));
    end
    chk("k2n2_err", 32'(err), 0);
    @(posedge clk); #1;
    // zero counts behave as a single tile, done 7 cycles after acceptance
    op_q.delete(); arg_q.delete();
    submit(0, 0);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!job_done && lat < 50);
    chk("k0n0_lat", 32'(lat), 7);
    chk("k0n0_len", 32'(op_q.size()), 3);
    if (op_q.size() == 3) begin
      chk("k0n0_op1", 32'(op_q[1]), 32'(OP_FEED_CLR));
      chk("k0n0_op2", 32'(op_q[2]), 32'(OP_REQUANT));
      chk("k0n0_arg2", 32'(arg_q[2]), 0);
    end
    @(posedge clk); #1;
    // cb ready stalled for 5 cycles
    cb_cmd_ready = 0;
    submit(1, 1);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) cb_cmd_ready = 1;
      @(negedge clk);
      chk($sformatf("stall_valid%0d", i), 32'(cb_cmd_valid), 1);
      chk($sformatf("stall_op%0d", i), 32'(cmd_op), 32'(OP_LOAD_W));
      chk($sformatf("stall_arg%0d", i), 32'(cmd_arg), 0);
      chk($sformatf("stall_other%0d", i), 32'({rb_cmd_valid, rq_cmd_valid}), 0);
      @(posedge clk); #1;
    end
    wait_done("stall_done");
    @(posedge clk); #1;
    // done coincident with its own handshake is early
    auto_done = 0;
    submit(1, 1);
    cb_done = 1;
    @(posedge clk); #1 cb_done = 0;
    @(negedge clk);
    chk("early_err", 32'(err), 1);
    chk("early_no_feed", 32'(rb_cmd_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("early_hold", 32'(rb_cmd_valid), 0);
    chk("early_busy", 32'(busy), 1);
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    wait_done("early_abort_done");
    @(posedge clk); #1;
    // stray rq_done in WAIT_W
    submit(1, 1);
    @(negedge clk);
    chk("accept_clears_err", 32'(err), 0);
    @(posedge clk); #1 rq_done = 1;
    @(posedge clk); #1 rq_done = 0;
    @(negedge clk);
    chk("stray_err", 32'(err), 1);
    chk("stray_hold", 32'({cb_cmd_valid, rb_cmd_valid, rq_cmd_valid}), 0);
    @(posedge clk); #1 cb_done = 1;
    @(posedge clk); #1 cb_done = 0; auto_done = 1;
    wait_done("stray_done");
    chk("err_sticky", 32'(err), 1);
    @(posedge clk); #1;
    // abort in WAIT_F of k=3,n=1
    submit(3, 1);
    c = 0;
    do begin @(negedge clk); c++; end while (!(rb_cmd_valid && rb_cmd_ready) && c < 50);
    @(posedge clk); #1 abort = 1;
    @(negedge clk);
    chk("abort_valids", 32'({cb_cmd_valid, rb_cmd_valid, rq_cmd_valid}), 0);
    chk("abort_no_done_yet", 32'(job_done), 0);
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    chk("abort_done", 32'(job_done), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_idle", 32'({job_ready, busy, job_done, err}), 32'b1000);
    @(posedge clk); #1;
    // reset during ISSUE_Q
    rq_cmd_ready = 0;
    submit(1, 1);
    c = 0;
    do begin @(negedge clk); c++; end while (!rq_cmd_valid && c < 50);
    chk("rq_reached", 32'(rq_cmd_valid), 1);
    #2 rstn = 0;
    #1;
    chk("rst_mid_rq_valid", 32'(rq_cmd_valid), 0);
    chk("rst_mid_idle", 32'({job_ready, busy}), 32'b10);
    jd_snap = jd_cnt;
    @(posedge clk); #1 rstn = 1; rq_cmd_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid_no_done", 32'(jd_cnt), 32'(jd_snap));
    @(posedge clk); #1;
    op_q.delete(); arg_q.delete();
    submit(2, 1);
    wait_done("post_rst_done");
    chk("post_rst_len", 32'(op_q.size()), 5);
    if (op_q.size() == 5) begin
      chk("post_rst_op3", 32'(op_q[3]), 32'(OP_FEED_ACC));
      chk("post_rst_op4", 32'(op_q[4]), 32'(OP_REQUANT));
      chk("post_rst_arg4", 32'(arg_q[4]), 32'h0001);
    end
    #1;
    chk("post_rst_jd", 32'(jd_cnt), 32'(jd_snap + 1));
    chk("multi_valid", 32'(multi_cnt), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
